// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

    localparam int CNT_W   = 8;
    localparam int DIV_MIN = 2;

    typedef logic [CNT_W-1:0] div_t;

    // Number of high cycles in a period of d cycles: ceil(d/2), computed
    // without d+1 so the widest divisor cannot overflow.
    function automatic div_t half_hi(div_t d);
        return (d >> 1) + div_t'(d[0]);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active divisor, a single pending
// divisor slot and the registered output.
// Optional DIV_TICK_EN adds a registered pulse on every rising output edge.
module clk_div_chan #(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             pend,
    output logic             clk_div
`ifdef DIV_TICK_EN
    ,
    output logic             tick
`endif
);

    localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cur_div;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] div_use;
    logic [CNT_W-1:0] half;
    logic             boundary;
    logic             swap;

    // Next count and high-phase length; a pending divisor shapes the period it starts.
    always_comb begin
        boundary = (cnt == cur_div - 1'b1);
        swap     = boundary & pend;
        div_use  = swap ? pend_div : cur_div;
        cnt_nxt  = boundary ? '0 : cnt + 1'b1;
        half     = (div_use >> 1) + {{(CNT_W-1){1'b0}}, div_use[0]};
    end

    // Counter, divisor swap, pending slot and output flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_div  <= DEF;
            cnt      <= DEF - 1'b1;
            pend     <= 1'b0;
            pend_div <= '0;
            clk_div  <= 1'b0;
        end else begin
            if (en) begin
                cnt     <= cnt_nxt;
                clk_div <= (cnt_nxt < half);
                if (swap) begin
                    cur_div <= pend_div;
                    pend    <= 1'b0;
                end
            end else begin
                clk_div <= 1'b0;
                if (pend) begin
                    cur_div <= pend_div;
                    cnt     <= pend_div - 1'b1;
                    pend    <= 1'b0;
                end else begin
                    cnt <= cur_div - 1'b1;
                end
            end
            // Writes are only accepted while pend is clear, so they never race the swap.
            if (wr) begin
                pend     <= 1'b1;
                pend_div <= wr_div;
            end
        end
    end

`ifdef DIV_TICK_EN
    // Pulse coincident with each rising edge of clk_div.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick <= 1'b0;
        end else begin
            tick <= en & (cnt_nxt == '0);
        end
    end
`endif

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider: config decode, ready mux,
// error flop and NCH generated channels.
// Optional DIV_TICK_EN adds the tick output port.
module prog_clk_divider #(
    parameter int NCH     = 3,
    parameter int CNT_W   = clk_div_pkg::CNT_W,
    parameter int DEF_DIV = 10,
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
    input  logic             cfg_valid,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
`ifdef DIV_TICK_EN
    output logic [NCH-1:0]   tick,
`endif
    output logic [NCH-1:0]   clk_div
);

    import clk_div_pkg::*;

    logic [NCH-1:0] pend;
    logic [NCH-1:0] wr;
    logic           ch_hit;
    logic           accept;
    logic           legal;

    // Channel decode; an out-of-range channel is never blocked so it can be flagged.
    always_comb begin
        ch_hit    = 1'b0;
        cfg_ready = 1'b1;
        wr        = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                ch_hit    = 1'b1;
                cfg_ready = ~pend[i];
            end
        end
        accept = cfg_valid & cfg_ready;
        legal  = ch_hit & (cfg_div >= CNT_W'(DIV_MIN));
        for (int unsigned i = 0; i < NCH; i++) begin
            wr[i] = accept & legal & (cfg_ch == CH_W'(i));
        end
    end

    // One-cycle error pulse for an accepted but illegal write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= accept & ~legal;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en[g]),
            .wr      (wr[g]),
            .wr_div  (cfg_div),
            .pend    (pend[g]),
            .clk_div (clk_div[g])
`ifdef DIV_TICK_EN
            ,
            .tick    (tick[g])
`endif
        );
    end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Self-checking bench for prog_clk_divider against a waveform-queue model.
// Honours DIV_TICK_EN when the design is built with it.
module tb_prog_clk_divider;

    localparam int NCH   = 3;
    localparam int CNT_W = 8;
    localparam int DEF   = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NCH-1:0]   en = '0;
    logic             cfg_valid = 1'b0;
    logic [1:0]       cfg_ch = '0;
    logic [CNT_W-1:0] cfg_div = '0;
    logic             cfg_ready;
    logic             cfg_err;
    logic [NCH-1:0]   clk_div;
`ifdef DIV_TICK_EN
    logic [NCH-1:0]   tick;
`endif

    int checks   = 0;
    int failures = 0;

    // Model: each channel holds the remaining samples of its current period.
    int m_cur  [NCH];
    int m_pdiv [NCH];
    bit m_pend [NCH];
    bit mq     [NCH][$];
    bit e_clk  [NCH];
    bit e_tick [NCH];
    bit e_err;

    always #5 clk = ~clk;

    prog_clk_divider #(
        .NCH     (NCH),
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
`ifdef DIV_TICK_EN
        .tick      (tick),
`endif
        .clk_div   (clk_div)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cur[i]  = DEF;
            m_pdiv[i] = 0;
            m_pend[i] = 1'b0;
            mq[i].delete();
            e_clk[i]  = 1'b0;
            e_tick[i] = 1'b0;
        end
        e_err = 1'b0;
    endtask

    task automatic check_outputs(input string where);
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("%s clk_div[%0d]", where, i), {31'b0, clk_div[i]}, {31'b0, e_clk[i]});
`ifdef DIV_TICK_EN
            chk($sformatf("%s tick[%0d]", where, i), {31'b0, tick[i]}, {31'b0, e_tick[i]});
`endif
        end
        chk({where, " cfg_err"}, {31'b0, cfg_err}, {31'b0, e_err});
    endtask

    // One clock: drive inputs, predict the edge, then compare after it.
    task automatic step(input logic [NCH-1:0] e, input logic v, input logic [1:0] ch,
                        input int dv, input string where);
        bit ready, legal, accept;
        int d;
        en        = e;
        cfg_valid = v;
        cfg_ch    = ch;
        cfg_div   = CNT_W'(dv);
        #1;
        ready = (int'(ch) < NCH) ? !m_pend[ch] : 1'b1;
        chk({where, " cfg_ready"}, {31'b0, cfg_ready}, {31'b0, ready});
        legal  = (int'(ch) < NCH) && (dv >= 2);
        accept = v && ready;
        for (int i = 0; i < NCH; i++) begin
            if (e[i]) begin
                e_tick[i] = 1'b0;
                if (mq[i].size() == 0) begin
                    d = m_pend[i] ? m_pdiv[i] : m_cur[i];
                    m_cur[i]  = d;
                    m_pend[i] = 1'b0;
                    for (int k = 0; k < d; k++) mq[i].push_back(k < (d + 1) / 2);
                    e_tick[i] = 1'b1;
                end
                e_clk[i] = mq[i].pop_front();
            end else begin
                mq[i].delete();
                e_clk[i]  = 1'b0;
                e_tick[i] = 1'b0;
                if (m_pend[i]) begin
                    m_cur[i]  = m_pdiv[i];
                    m_pend[i] = 1'b0;
                end
            end
        end
        if (accept && legal) begin
            m_pend[ch] = 1'b1;
            m_pdiv[ch] = dv;
        end
        e_err = accept && !legal;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        check_outputs(where);
    endtask

    task automatic run(input int n, input logic [NCH-1:0] e, input string where);
        for (int i = 0; i < n; i++) step(e, 1'b0, 2'd0, 0, where);
    endtask

    initial begin
        bool_search : begin end
        model_reset();
        #3;
        check_outputs("in_reset");
        chk("in_reset cfg_ready", {31'b0, cfg_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Default divisor on all channels, first rise one clock after enable.
        run(25, '1, "default");

        // Channel 1 reprogrammed to 3 mid-period.
        run(3, '1, "pre_d3");
        step('1, 1'b1, 2'd1, 3, "wr_ch1_d3");
        run(30, '1, "ch1_d3");

        // Write to channel 0 exactly on a boundary edge, then a blocked second write.
        begin
            int n = 0;
            while (mq[0].size() != 0 && n < 300) begin
                step('1, 1'b0, 2'd0, 0, "seek_boundary");
                n++;
            end
            chk("boundary_found", {31'b0, (mq[0].size() == 0)}, 32'd1);
        end
        step('1, 1'b1, 2'd0, 2, "wr_ch0_on_boundary");
        chk("second_write_blocked", {31'b0, cfg_ready}, 32'd0);
        step('1, 1'b1, 2'd0, 7, "wr_ch0_blocked");
        run(30, '1, "ch0_d2");

        // Illegal writes are acknowledged and flagged without effect.
        step('1, 1'b1, 2'd1, 1, "err_div1");
        step('1, 1'b1, 2'd3, 5, "err_ch3");
        step('1, 1'b1, 2'd2, 0, "err_div0");
        run(12, '1, "after_err");

        // Channel 2 disabled with a pending write, then re-enabled.
        step('1, 1'b1, 2'd2, 4, "wr_ch2_d4");
        run(7, 3'b011, "ch2_off");
        run(16, '1, "ch2_reen");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [NCH-1:0] e;
            int dv, sel;
            for (int b = 0; b < NCH; b++) e[b] = ($urandom_range(0, 7) != 0);
            sel = $urandom_range(0, 15);
            if (sel == 0)      dv = $urandom_range(0, 1);
            else if (sel == 1) dv = 255;
            else               dv = $urandom_range(2, 12);
            step(e, ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), dv, "random");
        end

        // Asynchronous reset during a high phase drops any pending write.
        run(2, '1, "pre_rst");
        step('1, 1'b1, 2'd0, 5, "wr_before_rst");
        begin
            int n = 0;
            while (!(e_clk[1] && mq[1].size() > 0) && n < 600) begin
                step('1, 1'b0, 2'd0, 0, "seek_high");
                n++;
            end
            chk("high_phase_found", {31'b0, e_clk[1]}, 32'd1);
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        chk("async_rst cfg_ready", {31'b0, cfg_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(30, '1, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
